// File: rtl/matrix_mult_seq_ctrl.sv
// matrix_mult_seq_ctrl: loads A then B from one valid/ready stream, drives matrix_mult_parallel_flat,
// captures C after a settle time and streams it back out row-major. Define MMC_PERF_CNT_EN for perf_cycles.
module matrix_mult_seq_ctrl #(
  parameter int MAX_SIZE      = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic [7:0]                               size_in,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     err,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [DATA_WIDTH-1:0]                    in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [DATA_WIDTH-1:0]                    out_data,
  output logic                                     out_last,
  output logic [31:0]                              mm_size,
  output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]  mm_a,
  output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]  mm_b,
  input  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]  mm_c
`ifdef MMC_PERF_CNT_EN
  ,
  output logic [31:0]                              perf_cycles
`endif
);

  localparam int FLAT_W = MAX_SIZE * MAX_SIZE * DATA_WIDTH;
  localparam int LSB_W  = $clog2(FLAT_W);
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [7:0]         n_size, row, col;
  logic [SET_W-1:0]   settle_cnt;
  logic [FLAT_W-1:0]  a_mat, b_mat, c_mat;
  logic [LSB_W-1:0]   slot_lsb;
  logic               size_ok, start_ok, in_beat, out_beat, step, at_last, settle_end;

  assign size_ok    = (size_in != 8'd0) && (size_in <= 8'(MAX_SIZE));
  assign start_ok   = (state == IDLE) && start && size_ok;
  assign busy       = (state != IDLE);
  assign in_ready   = (state == LOAD_A) || (state == LOAD_B);
  assign in_beat    = in_valid && in_ready;
  assign out_valid  = (state == DRAIN);
  assign out_beat   = out_valid && out_ready;
  assign step       = in_beat || out_beat;
  assign at_last    = (row == n_size - 8'd1) && (col == n_size - 8'd1);
  assign settle_end = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));

  // Element (row,col) lives at the same flat slot for A, B and C.
  assign slot_lsb = LSB_W'((32'(row) * MAX_SIZE + 32'(col)) * DATA_WIDTH);

  assign out_data = c_mat[slot_lsb +: DATA_WIDTH];
  assign out_last = out_valid && at_last;
  assign mm_a     = a_mat;
  assign mm_b     = b_mat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)            state_nxt = LOAD_A;
      LOAD_A:  if (in_beat && at_last)  state_nxt = LOAD_B;
      LOAD_B:  if (in_beat && at_last)  state_nxt = COMPUTE;
      COMPUTE: if (settle_end)          state_nxt = DRAIN;
      DRAIN:   if (out_beat && at_last) state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_size     <= 8'd0;
      row        <= 8'd0;
      col        <= 8'd0;
      settle_cnt <= '0;
      a_mat      <= '0;
      b_mat      <= '0;
      c_mat      <= '0;
      mm_size    <= 32'd0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= out_beat && at_last;
      err  <= (state == IDLE) && start && !size_ok;
      // A new job clears both operands so slots outside NxN read zero.
      if (start_ok) begin
        n_size  <= size_in;
        mm_size <= {24'd0, size_in};
        a_mat   <= '0;
        b_mat   <= '0;
        row     <= 8'd0;
        col     <= 8'd0;
      end
      if (step) begin
        if (col == n_size - 8'd1) begin
          col <= 8'd0;
          row <= at_last ? 8'd0 : row + 8'd1;
        end else begin
          col <= col + 8'd1;
        end
      end
      if (in_beat && (state == LOAD_A)) a_mat[slot_lsb +: DATA_WIDTH] <= in_data;
      if (in_beat && (state == LOAD_B)) b_mat[slot_lsb +: DATA_WIDTH] <= in_data;
      if (state == COMPUTE) begin
        settle_cnt <= settle_end ? '0 : settle_cnt + 1'b1;
        if (settle_end) c_mat <= mm_c;
      end
    end
  end

`ifdef MMC_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        perf_cycles <= 32'd0;
    else if (start_ok) perf_cycles <= 32'd0;
    else if (busy)     perf_cycles <= sat_inc(perf_cycles);
  end
`endif

endmodule

// File: tb/tb_matrix_mult_seq_ctrl.sv
// Scoreboard bench for matrix_mult_seq_ctrl with a behavioural datapath stub and reference model.
module tb_matrix_mult_seq_ctrl;

  localparam int MAX    = 10;
  localparam int DW     = 32;
  localparam int SETTLE = 2;
  localparam int FLAT_W = MAX * MAX * DW;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [7:0]        size_in;
  logic              busy, done, err;
  logic              in_valid, in_ready;
  logic [DW-1:0]     in_data;
  logic              out_valid, out_ready, out_last;
  logic [DW-1:0]     out_data;
  logic [31:0]       mm_size;
  logic [FLAT_W-1:0] mm_a, mm_b, mm_c;
`ifdef MMC_PERF_CNT_EN
  logic [31:0]       perf_cycles;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            or_mode = 0;
  logic [DW-1:0] ma[MAX][MAX];
  logic [DW-1:0] mb[MAX][MAX];

  matrix_mult_seq_ctrl #(.MAX_SIZE(MAX), .DATA_WIDTH(DW), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size_in(size_in),
    .busy(busy), .done(done), .err(err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .mm_size(mm_size), .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c)
`ifdef MMC_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] slot_get(input logic [FLAT_W-1:0] f, input int idx);
    return DW'(f >> (idx * DW));
  endfunction

  // Stand-in for the parallel multiplier array: C = A*B over the top-left NxN, mod 2^DW.
  function automatic logic [FLAT_W-1:0] datapath(input logic [FLAT_W-1:0] a,
                                                 input logic [FLAT_W-1:0] b,
                                                 input logic [31:0] size);
    logic [FLAT_W-1:0] c;
    logic [DW-1:0]     acc;
    int                n;
    c = '0;
    n = (size > 32'(MAX)) ? MAX : int'(size);
    for (int r = 0; r < n; r++)
      for (int cc = 0; cc < n; cc++) begin
        acc = '0;
        for (int k = 0; k < n; k++)
          acc = acc + slot_get(a, r * MAX + k) * slot_get(b, k * MAX + cc);
        c = c | (FLAT_W'(acc) << ((r * MAX + cc) * DW));
      end
    return c;
  endfunction

  assign mm_c = datapath(mm_a, mm_b, mm_size);

  function automatic logic [FLAT_W-1:0] flat_of(input bit sel_b, input int n);
    logic [FLAT_W-1:0] f;
    f = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        f = f | (FLAT_W'(sel_b ? mb[r][c] : ma[r][c]) << ((r * MAX + c) * DW));
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_flat(input string name, input logic [FLAT_W-1:0] act, input logic [FLAT_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      for (int i = 0; i < MAX * MAX; i++)
        if (slot_get(act, i) !== slot_get(exp, i)) begin
          $display("FAIL %s slot %0d: got %0h expected %0h", name, i, slot_get(act, i), slot_get(exp, i));
          break;
        end
    end
  endtask

  // Reference model: row-major C elements in output order.
  task automatic push_expected(input int n);
    logic [DW-1:0] acc;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        acc = '0;
        for (int k = 0; k < n; k++) acc = acc + ma[r][k] * mb[k][c];
        exp_q.push_back('{data: acc, last: (r == n - 1) && (c == n - 1)});
      end
  endtask

  // Output monitor: pops the scoreboard on every accepted C beat and tracks done/err pulses.
  initial begin : monitor
    exp_t          e;
    logic          err_exp, done_exp, prev_stall, prev_last;
    logic [DW-1:0] prev_data;
    err_exp = 0; done_exp = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        err_exp = 0; done_exp = 0; prev_stall = 0;
      end else begin
        if (err || err_exp)   check("err_pulse_mon", err, err_exp);
        if (done || done_exp) check("done_pulse_mon", done, done_exp);
        if (prev_stall && out_valid) begin
          check("stall_data_hold", out_data, prev_data);
          check("stall_last_hold", out_last, prev_last);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_c_beat: got %0h expected none", out_data);
          end else begin
            e = exp_q.pop_front();
            check("c_data", out_data, e.data);
            check("c_last", out_last, e.last);
          end
        end
        err_exp    = start && !busy && ((size_in == 8'd0) || (size_in > 8'(MAX)));
        done_exp   = out_valid && out_ready && out_last;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  // Sink: 0 = always ready, 1 = toggle, 2 = random.
  initial begin : sink
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic start_job(input int n);
    @(posedge clk); #1;
    start = 1'b1; size_in = 8'(n);
    @(posedge clk); #1;
    start = 1'b0; size_in = 8'($urandom);
    check("busy_after_start", busy, 1);
  endtask

  task automatic send_elem(input logic [DW-1:0] d, input bit gaps);
    int cnt;
    bit ok;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      in_valid = 1'b0; in_data = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d; cnt = 0; ok = 0;
    while (!ok && cnt < 100) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      cnt++;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk); cnt++;
    end while ((busy || exp_q.size() != 0) && cnt < 3000);
    if (busy || exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: busy=%0d pending=%0d expected 0 0", busy, exp_q.size());
    end
  endtask

  task automatic run_job(input int n, input bit gaps, input bit poke, input int abort_b);
    start_job(n);
    if (poke) begin
      start = 1'b1; size_in = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) send_elem(ma[r][c], gaps);
    for (int i = 0; i < n * n; i++) begin
      if (i == abort_b) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_mm_size", mm_size, 0);
        check_flat("abort_mm_a", mm_a, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      send_elem(mb[i / n][i % n], gaps);
    end
    push_expected(n);
    wait_idle();
    check_flat("mm_a_hold", mm_a, flat_of(0, n));
    check_flat("mm_b_hold", mm_b, flat_of(1, n));
    check("mm_size_hold", mm_size, 32'(n));
  endtask

  task automatic bad_start(input int s);
    @(posedge clk); #1;
    start = 1'b1; size_in = 8'(s);
    @(posedge clk); #1;
    start = 1'b0;
    check("bad_busy", busy, 0);
    check("bad_in_ready", in_ready, 0);
    check("bad_err", err, 1);
    @(posedge clk); #1;
    check("bad_err_clear", err, 0);
    check("bad_busy_after", busy, 0);
  endtask

  task automatic fill_random(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        ma[r][c] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
        mb[r][c] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
      end
  endtask

  initial begin : stim
    int n;
    rst_n = 1'b1; start = 1'b0; size_in = 8'd0; in_valid = 1'b0; in_data = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mm_size", mm_size, 0);
    check_flat("rst_mm_a", mm_a, '0);
    check_flat("rst_mm_b", mm_b, '0);
`ifdef MMC_PERF_CNT_EN
    check("rst_perf", perf_cycles, 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;

    // 2x2 directed job
    or_mode = 0;
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    run_job(2, 0, 1, -1);

    // Out-of-range sizes
    bad_start(0);
    bad_start(MAX + 1);
    bad_start(255);

    // Identity times 1..9 with a toggling sink
    or_mode = 1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = (r == c) ? 32'd1 : 32'd0;
        mb[r][c] = 32'(r * 3 + c + 1);
      end
    run_job(3, 1, 1, -1);

    // All-ones 3x3 followed by 2x2: leftover slots must read zero
    or_mode = 2;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = 32'hFFFF_FFFF;
        mb[r][c] = 32'hFFFF_FFFF;
      end
    run_job(3, 1, 0, -1);
    fill_random(2);
    run_job(2, 1, 1, -1);

    // Reset during LOAD_B, then a 1x1 job
    fill_random(3);
    run_job(3, 0, 0, 4);
    or_mode = 0;
    ma[0][0] = 7; mb[0][0] = 6;
    run_job(1, 0, 0, -1);

`ifdef MMC_PERF_CNT_EN
    ma[0][0] = 3; mb[0][0] = 9;
    run_job(1, 0, 0, -1);
    check("perf_at_done", perf_cycles, 5);
    repeat (3) @(posedge clk);
    #1 check("perf_frozen", perf_cycles, 5);
`endif

    // Randomized jobs
    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(1, MAX);
      fill_random(n);
      or_mode = $urandom_range(0, 2);
      run_job(n, 1'($urandom_range(0, 1)), 1, -1);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
